// File: rtl/div_ctrl.sv
// div_ctrl: sequencing front-end for the iterative 32-bit divider (RV32M DIV/DIVU/REM/REMU).
// Latency: 35 cycles accept->rsp_valid through the divider; 1 cycle for div-by-zero,
//          signed overflow and (with DIV_CTRL_REUSE_EN defined) result-cache hits.
// Backpressure: one operation in flight; req_ready only in IDLE without flush, response
//          held stable in RESP until rsp_ready; flush drops the in-flight/pending result.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   flush               kill in-flight or pending operation
//   req_*               request handshake: op (00 DIV, 01 DIVU, 10 REM, 11 REMU), a, b, rd tag
//   rsp_*               response handshake: data, rd tag
//   div_*               divider launch (start/sign/operands) and results (quotient/remainder/busy)
//
// Optional feature: define DIV_CTRL_REUSE_EN to enable a one-entry cache of the last
// divider-computed result, so DIV followed by REM (or vice versa) on the same operands
// answers without relaunching the divider.
module div_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        div_start,
  output logic        div_sign,
  output logic [31:0] div_divident,
  output logic [31:0] div_divisor,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder,
  input  logic        div_busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        rem_sel_q, rem_sel_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] data_q, data_d;

  logic        accept;
  logic        req_signed;
  logic        div_by_zero;
  logic        overflow;
  logic        special;
  logic        hit;
  logic [31:0] hit_data;
  logic [31:0] early_data;
  logic        div_capture;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  assign req_signed  = ~req_op[0];
  assign div_by_zero = (req_b == 32'h0000_0000);
  // Only INT_MIN / -1 overflows; the divider is never asked to handle it.
  assign overflow    = req_signed && (req_a == 32'h8000_0000) && (req_b == 32'hFFFF_FFFF);
  assign special     = div_by_zero || overflow;

  assign req_ready   = (state_q == S_IDLE) && !flush;
  assign accept      = req_valid && req_ready;

  // Launch pulse is combinational in the accept cycle so the divider's busy window
  // starts on the very next edge; accept only happens in IDLE, so the divider can
  // never be restarted while it is still iterating.
  assign div_start    = accept && !special && !hit;
  assign div_sign     = req_signed;
  assign div_divident = req_a;
  assign div_divisor  = req_b;

  // A result is taken from the divider only on the cycle busy has dropped and the
  // operation was not flushed; a flushed operation goes through DRAIN instead.
  assign div_capture = (state_q == S_WAIT) && !flush && !div_busy;

  // ---------------------------------------------------------------------------
  // Optional one-entry result cache
  // ---------------------------------------------------------------------------
`ifdef DIV_CTRL_REUSE_EN
  logic        c_vld_q;
  logic [31:0] c_a_q;
  logic [31:0] c_b_q;
  logic        c_sign_q;
  logic [31:0] c_quo_q;
  logic [31:0] c_rem_q;

  // Operands of the launched operation, kept so the cache can be tagged once the
  // divider finishes (the request bus has moved on by then).
  logic [31:0] op_a_q;
  logic [31:0] op_b_q;
  logic        op_sign_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_a_q    <= 32'h0;
      op_b_q    <= 32'h0;
      op_sign_q <= 1'b0;
    end else if (div_start) begin
      op_a_q    <= req_a;
      op_b_q    <= req_b;
      op_sign_q <= req_signed;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_vld_q  <= 1'b0;
      c_a_q    <= 32'h0;
      c_b_q    <= 32'h0;
      c_sign_q <= 1'b0;
      c_quo_q  <= 32'h0;
      c_rem_q  <= 32'h0;
    end else if (div_capture) begin
      c_vld_q  <= 1'b1;
      c_a_q    <= op_a_q;
      c_b_q    <= op_b_q;
      c_sign_q <= op_sign_q;
      c_quo_q  <= div_quotient;
      c_rem_q  <= div_remainder;
    end
  end

  // Both quotient and remainder are stored, so the opposite flavour of the same
  // division (DIV then REM) hits as long as operands and signedness match.
  assign hit      = c_vld_q && (c_a_q == req_a) && (c_b_q == req_b) && (c_sign_q == req_signed);
  assign hit_data = req_op[1] ? c_rem_q : c_quo_q;
`else
  assign hit      = 1'b0;
  assign hit_data = 32'h0;
`endif

  // ---------------------------------------------------------------------------
  // Result for operations answered without the divider
  // ---------------------------------------------------------------------------
  always_comb begin
    early_data = hit_data;
    if (div_by_zero) begin
      early_data = req_op[1] ? req_a : 32'hFFFF_FFFF;
    end else if (overflow) begin
      early_data = req_op[1] ? 32'h0000_0000 : 32'h8000_0000;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      rem_sel_q <= 1'b0;
      rd_q      <= 5'd0;
      data_q    <= 32'h0;
    end else begin
      state_q   <= state_d;
      rem_sel_q <= rem_sel_d;
      rd_q      <= rd_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    rem_sel_d = rem_sel_q;
    rd_d      = rd_q;
    data_d    = data_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          rem_sel_d = req_op[1];
          rd_d      = req_rd;
          if (special || hit) begin
            data_d  = early_data;
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        // Flush has priority over a same-cycle capture; the divider still has to
        // run out before anything new may be launched.
        if (flush) begin
          state_d = S_DRAIN;
        end else if (!div_busy) begin
          data_d  = rem_sel_q ? div_remainder : div_quotient;
          state_d = S_RESP;
        end
      end

      S_DRAIN: begin
        if (!div_busy) begin
          state_d = S_IDLE;
        end
      end

      S_RESP: begin
        // flush together with rsp_ready drops the response rather than handing it over.
        if (flush || rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rsp_valid = (state_q == S_RESP);
  assign rsp_data  = data_q;
  assign rsp_rd    = rd_q;

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [4:0]  req_rd;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        div_start;
  logic        div_sign;
  logic [31:0] div_divident;
  logic [31:0] div_divisor;
  logic [31:0] div_quotient;
  logic [31:0] div_remainder;
  logic        div_busy;

  always #5 clk = ~clk;

  div_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .req_rd       (req_rd),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_rd       (rsp_rd),
    .div_start    (div_start),
    .div_sign     (div_sign),
    .div_divident (div_divident),
    .div_divisor  (div_divisor),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder),
    .div_busy     (div_busy)
  );

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;
  localparam int         LAT_DIV = 35;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------------------------------------------------------------------
  // Reference: RV32M division rules computed in 64-bit arithmetic
  // ---------------------------------------------------------------------------
  function automatic logic [63:0] wide_divide(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'h0) return {32'hFFFF_FFFF, a};
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q = sa / sb;   // INT_MIN / -1 = +2^31, which truncates to 0x80000000
    r = sa % sb;
    return {q[31:0], r[31:0]};
  endfunction

  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] qr;
    qr = wide_divide(!op[0], a, b);
    return op[1] ? qr[31:0] : qr[63:32];
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'h0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  // Model of the last divider-computed operands (only matters with the cache build).
  bit          m_c_vld = 1'b0;
  logic [31:0] m_c_a, m_c_b;
  logic        m_c_sign;

  function automatic int exp_latency(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (is_special(op, a, b)) return 1;
`ifdef DIV_CTRL_REUSE_EN
    if (m_c_vld && m_c_a == a && m_c_b == b && m_c_sign == !op[0]) return 1;
`endif
    return LAT_DIV;
  endfunction

  // ---------------------------------------------------------------------------
  // Divider model: busy cycles 1..33 after the launch cycle, results valid after.
  // Outputs are scrambled while busy so an early capture shows up as wrong data.
  // ---------------------------------------------------------------------------
  int          dcnt;
  logic [31:0] dq_fin, dr_fin;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_busy <= 1'b0;
      dcnt     <= 0;
      dq_fin   <= 32'h0;
      dr_fin   <= 32'h0;
    end else if (div_start) begin
      div_busy         <= 1'b1;
      dcnt             <= 33;
      {dq_fin, dr_fin} <= wide_divide(div_sign, div_divident, div_divisor);
    end else if (div_busy) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) div_busy <= 1'b0;
    end
  end
  assign div_quotient  = div_busy ? ~dq_fin : dq_fin;
  assign div_remainder = div_busy ? ~dr_fin : dr_fin;

  // The divider must never be relaunched while busy or outside an accept.
  always @(posedge clk) begin
    if (reset_n && div_start && (div_busy || !req_ready || !req_valid)) begin
      n_fail++;
      $display("FAIL start_illegal: div_start=1 with busy=%0b req_ready=%0b req_valid=%0b, required div_start=0",
               div_busy, req_ready, req_valid);
    end
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    #1;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
      #1;
    end
    if (!req_ready) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s ready_timeout: req_ready=0 after 100 cycles, required 1", name);
    end
  endtask

  // One request, response and handshake; hold = cycles rsp_ready stays low after rsp_valid.
  task automatic run_req(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] exp_data, input int exp_lat, input int hold);
    int lat;
    bit got;
    wait_ready(name);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_rd    = rd;
    #1;
    chk({name, " div_start"}, {31'h0, div_start}, {31'h0, exp_lat == LAT_DIV});
    if (exp_lat == LAT_DIV) begin
      chk({name, " div_sign"}, {31'h0, div_sign}, {31'h0, !op[0]});
      chk({name, " div_operands"}, div_divident ^ div_divisor, a ^ b);
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 80) begin
      @(negedge clk);
      req_valid = 1'b0;
      lat++;
      #1;
      if (rsp_valid) got = 1'b1;
    end
    chk({name, " latency"}, lat, exp_lat);
    if (got) begin
      chk({name, " rsp_data"}, rsp_data, exp_data);
      chk({name, " rsp_rd"}, {27'h0, rsp_rd}, {27'h0, rd});
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        #1;
        chk({name, " hold_valid"}, {31'h0, rsp_valid}, 32'd1);
        chk({name, " hold_data"}, rsp_data, exp_data);
        chk({name, " hold_rd"}, {27'h0, rsp_rd}, {27'h0, rd});
        chk({name, " hold_req_ready"}, {31'h0, req_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
    end
    if (exp_lat == LAT_DIV) begin
      m_c_vld  = 1'b1;
      m_c_a    = a;
      m_c_b    = b;
      m_c_sign = !op[0];
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] data;
    int          lat;
    int          lat_reuse;
  } vec_t;

  vec_t vt[15];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          ready_bad, rsp_bad, elat, hold, r;
    logic [1:0]  op;
    logic [31:0] a, b, e;
    logic [4:0]  rd;

    vt[0]  = '{OP_DIVU, 32'd100,        32'd7,          5'd5,  32'd14,         35, 35};
    vt[1]  = '{OP_REMU, 32'd100,        32'd7,          5'd5,  32'd2,          35, 1};
    vt[2]  = '{OP_DIV,  32'hFFFF_FF9C,  32'd7,          5'd7,  32'hFFFF_FFF2,  35, 35};
    vt[3]  = '{OP_REM,  32'hFFFF_FF9C,  32'd7,          5'd8,  32'hFFFF_FFFE,  35, 1};
    vt[4]  = '{OP_DIV,  32'hFFFF_FFF9,  32'd0,          5'd9,  32'hFFFF_FFFF,  1,  1};
    vt[5]  = '{OP_REMU, 32'd9,          32'd0,          5'd10, 32'd9,          1,  1};
    vt[6]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd11, 32'h8000_0000,  1,  1};
    vt[7]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'd0,          1,  1};
    vt[8]  = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'd0,          35, 35};
    vt[9]  = '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'h8000_0000,  35, 1};
    vt[10] = '{OP_DIV,  32'd100,        32'd7,          5'd15, 32'd14,         35, 35};
    vt[11] = '{OP_REM,  32'd100,        32'd7,          5'd16, 32'd2,          35, 1};
    vt[12] = '{OP_DIVU, 32'd100,        32'd7,          5'd17, 32'd14,         35, 35};
    vt[13] = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  5'd18, 32'hFFFF_FFFD,  35, 35};
    vt[14] = '{OP_REMU, 32'hFFFF_FFFF,  32'd16,         5'd31, 32'd15,         35, 35};

    reset_n   = 1'b0;
    flush     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_a     = 32'h0;
    req_b     = 32'h0;
    req_rd    = 5'd0;
    rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("reset req_ready", {31'h0, req_ready}, 32'd1);
    chk("reset rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("reset rsp_data", rsp_data, 32'h0);
    chk("reset rsp_rd", {27'h0, rsp_rd}, 32'h0);
    chk("reset div_start", {31'h0, div_start}, 32'd0);

    foreach (vt[i]) begin
`ifdef DIV_CTRL_REUSE_EN
      elat = vt[i].lat_reuse;
`else
      elat = vt[i].lat;
`endif
      run_req($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, vt[i].rd, vt[i].data, elat, 0);
    end

    // Flush at cycle 10 of DIVU 100/7: no response, accepts blocked while the divider drains.
    wait_ready("flush_wait");
    req_valid = 1'b1; req_op = OP_DIVU; req_a = 32'd100; req_b = 32'd7; req_rd = 5'd4;
    #1;
    chk("flush_wait div_start", {31'h0, div_start}, 32'd1);
    ready_bad = 0;
    rsp_bad   = 0;
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      flush     = (c == 10);
      #1;
      if (c >= 10 && c <= 33 && req_ready) ready_bad++;
      if (rsp_valid) rsp_bad++;
      if (c == 35) chk("flush_wait ready_after_drain", {31'h0, req_ready}, 32'd1);
    end
    chk("flush_wait ready_during_drain", ready_bad, 0);
    chk("flush_wait no_response", rsp_bad, 0);
    run_req("after_flush", OP_DIVU, 32'd50, 32'd3, 5'd6, 32'd16, exp_latency(OP_DIVU, 32'd50, 32'd3), 0);

    // Consumer stall for 5 cycles.
    run_req("stall", OP_DIVU, 32'd1000, 32'd10, 5'd3, 32'd100, exp_latency(OP_DIVU, 32'd1000, 32'd10), 5);

    // Flush together with rsp_ready in RESP drops the response.
    wait_ready("flush_resp");
    req_valid = 1'b1; req_op = OP_DIV; req_a = 32'hFFFF_FFF9; req_b = 32'd0; req_rd = 5'd2;
    #1;
    chk("flush_resp div_start", {31'h0, div_start}, 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    #1;
    chk("flush_resp rsp_valid", {31'h0, rsp_valid}, 32'd1);
    chk("flush_resp rsp_data", rsp_data, 32'hFFFF_FFFF);
    flush     = 1'b1;
    rsp_ready = 1'b1;
    @(negedge clk);
    flush     = 1'b0;
    rsp_ready = 1'b0;
    #1;
    chk("flush_resp dropped", {31'h0, rsp_valid}, 32'd0);
    chk("flush_resp idle", {31'h0, req_ready}, 32'd1);

    // Reset while waiting on the divider.
    wait_ready("reset_wait");
    req_valid = 1'b1; req_op = OP_DIVU; req_a = 32'd100; req_b = 32'd7; req_rd = 5'd9;
    repeat (5) @(negedge clk);
    req_valid = 1'b0;
    reset_n   = 1'b0;
    #1;
    chk("reset_wait rsp_valid", {31'h0, rsp_valid}, 32'd0);
    chk("reset_wait req_ready", {31'h0, req_ready}, 32'd1);
    chk("reset_wait rsp_data", rsp_data, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    m_c_vld = 1'b0;
    run_req("after_reset", OP_DIVU, 32'd100, 32'd7, 5'd9, 32'd14, LAT_DIV, 0);

    // Randomized requests against the reference model.
    for (int i = 0; i < 150; i++) begin
      r  = $urandom_range(0, 9);
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      rd = 5'($urandom_range(0, 31));
      case (r)
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: if (m_c_vld) begin a = m_c_a; b = m_c_b; end
        3, 4: begin
          a = $urandom_range(0, 1000);
          b = $urandom_range(1, 50);
          if ($urandom_range(0, 1) == 1) a = -a;
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        default: ;
      endcase
      e    = ref_result(op, a, b);
      elat = exp_latency(op, a, b);
      hold = $urandom_range(0, 3);
      run_req($sformatf("rand%0d", i), op, a, b, rd, e, elat, hold);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
